// File: rtl/idli_uart_tx_m.sv
// Nibble-fed UART transmitter. Two nibbles (low first) form a byte. The byte
// goes into a 2-entry FIFO. An 8N1 serializer drains the FIFO, and each bit
// lasts BAUD_DIV clocks.
//
// state | meaning
// ------+-----------------------------------------------
// IDLE  | line high, waiting for a byte in the FIFO
// START | start bit (low) for BAUD_DIV cycles
// DATA  | 8 data bits, LSB first, BAUD_DIV cycles each
// STOP  | stop bit (high); chains straight into START
module idli_uart_tx_m #(
   parameter int BAUD_DIV = 16
) (
   input  logic       i_utx_gck,
   input  logic       i_utx_rst_n,
   input  logic [3:0] i_utx_data,
   input  logic       i_utx_vld,
   output logic       o_utx_acp,
   output logic       o_utx_tx,
   output logic       o_utx_busy
);

   localparam int             BW        = $clog2(BAUD_DIV);
   localparam logic [BW-1:0]  BAUD_LOAD = BW'(BAUD_DIV - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

   state_t        state, state_nxt;
   logic [3:0]    stage;
   logic          half;
   logic [7:0]    fifo_q [2];
   logic          wr_ptr, rd_ptr;
   logic [1:0]    count;
   logic [7:0]    shift, shift_nxt;
   logic [BW-1:0] baud_cnt, baud_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic          tx_q, tx_nxt;
   logic          xfer, push, pop, baud_tc;

   // Handshake decode. While a low nibble is staged, the FIFO always has room,
   // so a push can never hit a full FIFO.
   always_comb begin
      o_utx_acp  = half | (count < 2'd2);
      xfer       = i_utx_vld & o_utx_acp;
      push       = xfer & half;
      baud_tc    = (baud_cnt == '0);
      o_utx_tx   = tx_q;
      o_utx_busy = (state != ST_IDLE) | (count != 2'd0) | half;
   end

   // Serializer next-state logic; the baud down-counter reloads at every bit boundary.
   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_idx;
      shift_nxt = shift;
      tx_nxt    = tx_q;
      pop       = 1'b0;
      case (state)
         ST_IDLE: begin
            tx_nxt = 1'b1;
            if (count != 2'd0) begin
               pop       = 1'b1;
               shift_nxt = fifo_q[rd_ptr];
               state_nxt = ST_START;
               tx_nxt    = 1'b0;
               baud_nxt  = BAUD_LOAD;
            end
         end
         ST_START: begin
            if (baud_tc) begin
               state_nxt = ST_DATA;
               tx_nxt    = shift[0];
               bit_nxt   = 3'd0;
               baud_nxt  = BAUD_LOAD;
            end else begin
               baud_nxt = baud_cnt - 1'b1;
            end
         end
         ST_DATA: begin
            if (baud_tc) begin
               baud_nxt = BAUD_LOAD;
               bit_nxt  = bit_idx + 3'd1;
               if (bit_idx == 3'd7) begin
                  state_nxt = ST_STOP;
                  tx_nxt    = 1'b1;
               end else begin
                  shift_nxt = {1'b0, shift[7:1]};
                  tx_nxt    = shift[1];
               end
            end else begin
               baud_nxt = baud_cnt - 1'b1;
            end
         end
         ST_STOP: begin
            if (baud_tc) begin
               if (count != 2'd0) begin
                  pop       = 1'b1;
                  shift_nxt = fifo_q[rd_ptr];
                  state_nxt = ST_START;
                  tx_nxt    = 1'b0;
                  baud_nxt  = BAUD_LOAD;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end else begin
               baud_nxt = baud_cnt - 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State, staging and FIFO registers; reset drops any pending data.
   always_ff @(posedge i_utx_gck) begin
      if (!i_utx_rst_n) begin
         state     <= ST_IDLE;
         stage     <= 4'd0;
         half      <= 1'b0;
         fifo_q[0] <= 8'd0;
         fifo_q[1] <= 8'd0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         shift     <= 8'd0;
         baud_cnt  <= '0;
         bit_idx   <= 3'd0;
         tx_q      <= 1'b1;
      end else begin
         state    <= state_nxt;
         shift    <= shift_nxt;
         baud_cnt <= baud_nxt;
         bit_idx  <= bit_nxt;
         tx_q     <= tx_nxt;
         if (xfer) begin
            if (!half) stage <= i_utx_data;
            half <= ~half;
         end
         if (push) begin
            fifo_q[wr_ptr] <= {i_utx_data, stage};
            wr_ptr         <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_idli_uart_tx_m.sv
// Directed bench for idli_uart_tx_m with BAUD_DIV = 4. Bytes written are queued
// as expected frames. A line monitor rebuilds every 40-cycle frame from o_utx_tx.
// It compares each frame bit-for-bit against the ideal 8N1 waveform of the next
// queued byte.
module tb_idli_uart_tx_m;

   localparam int BD = 4;
   localparam int FL = 10 * BD;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] data = 4'd0;
   logic       vld = 1'b0;
   logic       acp, tx, busy;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   logic [7:0] exp_q [$];
   int         starts [$];
   int         frames_seen = 0;
   bit         collecting = 1'b0;

   idli_uart_tx_m #(.BAUD_DIV(BD)) dut (
      .i_utx_gck  (clk),
      .i_utx_rst_n(rst_n),
      .i_utx_data (data),
      .i_utx_vld  (vld),
      .o_utx_acp  (acp),
      .o_utx_tx   (tx),
      .o_utx_busy (busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a nibble and hold it until accepted; drv is the sample cycle whose following edge takes it.
   task automatic send_nib(input logic [3:0] d, output int drv);
      int n;
      vld  = 1'b1;
      data = d;
      drv  = -1;
      for (n = 0; n < 200 && drv < 0; n++) begin
         if (acp === 1'b1) drv = cyc;
         tick();
      end
      vld = 1'b0;
      if (drv < 0) chk("nib_accept_timeout", 64'(n), 64'(0));
   endtask

   task automatic send_byte(input logic [7:0] b, output int drv_hi);
      int d0;
      send_nib(b[3:0], d0);
      send_nib(b[7:4], drv_hi);
      exp_q.push_back(b);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || collecting) && n < budget) begin
         tick();
         n++;
      end
      chk("drain_left", 64'(exp_q.size()), 64'(0));
   endtask

   function automatic logic [39:0] frame_of(input logic [7:0] b);
      logic [39:0] f;
      for (int i = 0; i < FL; i++) begin
         if (i < BD)            f[i] = 1'b0;
         else if (i < 9 * BD)   f[i] = b[(i - BD) / BD];
         else                   f[i] = 1'b1;
      end
      return f;
   endfunction

   // Line monitor: collect each frame from its start bit and score it against the queue head.
   initial begin : monitor
      logic [39:0] obs;
      logic [7:0]  e;
      int          idx;
      idx = 0;
      obs = '0;
      forever begin
         @(posedge clk);
         #2;
         if (rst_n !== 1'b1) begin
            collecting = 1'b0;
            continue;
         end
         if (!collecting && tx === 1'b0) begin
            collecting = 1'b1;
            idx        = 0;
            starts.push_back(cyc);
         end
         if (collecting) begin
            obs[idx] = tx;
            idx++;
            if (idx == FL) begin
               collecting = 1'b0;
               frames_seen++;
               chk("frame_expected", 64'(exp_q.size() != 0), 64'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("frame_bits", 64'(obs), 64'(frame_of(e)));
               end
            end
         end
      end
   end

   initial begin : stim
      int d, s, n, f0;

      repeat (3) tick();
      chk("rst_tx", 64'(tx), 64'(1));
      rst_n = 1'b1;
      tick();
      chk("post_rst_acp", 64'(acp), 64'(1));
      chk("post_rst_busy", 64'(busy), 64'(0));
      chk("post_rst_tx", 64'(tx), 64'(1));

      // Single byte 0xA5 on consecutive cycles.
      starts.delete();
      send_byte(8'hA5, d);
      n = 0;
      while (starts.size() == 0 && n < 50) begin tick(); n++; end
      chk("t1_started", 64'(starts.size()), 64'(1));
      s = (starts.size() != 0) ? starts[0] : 0;
      chk("t1_start_cycle", 64'(s), 64'(d + 2));
      n = 0;
      while (busy === 1'b1 && n < 100) begin tick(); n++; end
      chk("t1_busy_fall", 64'(cyc), 64'(s + FL));
      wait_drain(100);

      // Back-to-back bytes, then a 10-cycle stall while the FIFO is full.
      starts.delete();
      send_byte(8'h11, d);
      send_byte(8'h22, d);
      send_byte(8'h33, d);
      chk("t2_full_acp", 64'(acp), 64'(0));
      chk("t2_full_busy", 64'(busy), 64'(1));
      vld = 1'b1;
      for (int i = 0; i < 10; i++) begin
         data = 4'(i + 7);
         chk("t4_stall_acp", 64'(acp), 64'(0));
         tick();
      end
      vld = 1'b0;
      wait_drain(400);
      chk("t2_frames", 64'(starts.size()), 64'(3));
      if (starts.size() == 3) begin
         chk("t2_gap01", 64'(starts[1] - starts[0]), 64'(FL));
         chk("t2_gap12", 64'(starts[2] - starts[1]), 64'(FL));
      end

      // Nibble gap: staging must survive idle cycles.
      send_nib(4'hF, d);
      repeat (5) tick();
      chk("t3_gap_busy", 64'(busy), 64'(1));
      chk("t3_gap_acp", 64'(acp), 64'(1));
      chk("t3_gap_tx", 64'(tx), 64'(1));
      send_nib(4'h0, d);
      exp_q.push_back(8'h0F);
      wait_drain(100);

      // Reset during data bit 3 with a second byte buffered.
      starts.delete();
      send_byte(8'hA5, d);
      send_byte(8'h3C, d);
      n = 0;
      while (starts.size() == 0 && n < 50) begin tick(); n++; end
      chk("t5_started", 64'(starts.size()), 64'(1));
      s = (starts.size() != 0) ? starts[0] : cyc;
      n = 0;
      while (cyc < s + 4 * BD && n < 100) begin tick(); n++; end
      chk("t5_bit3_tx", 64'(tx), 64'(0));
      chk("t5_bit3_busy", 64'(busy), 64'(1));
      rst_n = 1'b0;
      tick();
      chk("t5_rst_tx", 64'(tx), 64'(1));
      chk("t5_rst_busy", 64'(busy), 64'(0));
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      f0 = frames_seen;
      tick();
      chk("t5_rel_acp", 64'(acp), 64'(1));
      chk("t5_rel_busy", 64'(busy), 64'(0));
      chk("t5_rel_tx", 64'(tx), 64'(1));
      repeat (100) tick();
      chk("t5_no_frame", 64'(frames_seen - f0), 64'(0));
      chk("t5_no_start", 64'(starts.size()), 64'(1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
